// File: rtl/mips_cpu_muldiv_seq.sv
// mips_cpu_muldiv_seq: iterative 32-bit multiply/divide unit owning HI/LO.
// One bit per cycle shift-add multiply or restoring divide, with sign fixup in a final cycle.
module mips_cpu_muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DZ} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] r_q, r_d, q_q, q_d, m_q, m_d;
  logic        neg_q, neg_d, rneg_q, rneg_d, mul_q, mul_d, done_q, done_d;

  logic        is_mul, is_div, sgn, sa, sb, div_ok;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, div_sh;
  logic [33:0] div_diff;
  logic [63:0] prod, prod_fix;

  assign is_mul   = start & (op == OP_MULT | op == OP_MULTU);
  assign is_div   = start & (op == OP_DIV | op == OP_DIVU);
  assign sgn      = op == OP_MULT | op == OP_DIV;
  assign sa       = sgn & a[31];
  assign sb       = sgn & b[31];
  assign abs_a    = sa ? -a : a;
  assign abs_b    = sb ? -b : b;
  // r holds the accumulator/remainder, q the multiplier/quotient, m the multiplicand/divisor
  assign mul_sum  = {1'b0, r_q} + (q_q[0] ? {1'b0, m_q} : 33'd0);
  assign div_sh   = {r_q, q_q[31]};
  assign div_diff = {1'b0, div_sh} - {2'b0, m_q};
  assign div_ok   = ~div_diff[33];
  assign prod     = {r_q, q_q};
  assign prod_fix = neg_q ? -prod : prod;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    r_d     = r_q;
    q_d     = q_q;
    m_d     = m_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    mul_d   = mul_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mul | is_div) begin
          r_d     = '0;
          q_d     = is_mul ? abs_b : (b == '0 ? a : abs_a);
          m_d     = is_mul ? abs_a : abs_b;
          neg_d   = sa ^ sb;
          rneg_d  = sa;
          mul_d   = is_mul;
          cnt_d   = 5'd31;
          state_d = is_mul ? MUL : (b == '0 ? DZ : DIV);
        end else if (start & op == OP_MTHI) begin
          hi_d = a;
        end else if (start & op == OP_MTLO) begin
          lo_d = a;
        end
      end
      MUL: begin
        r_d     = mul_sum[32:1];
        q_d     = {mul_sum[0], q_q[31:1]};
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 5'd1;
        state_d = cnt_q == '0 ? FIX : MUL;
      end
      DIV: begin
        r_d     = div_ok ? div_diff[31:0] : div_sh[31:0];
        q_d     = {q_q[30:0], div_ok};
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 5'd1;
        state_d = cnt_q == '0 ? FIX : DIV;
      end
      FIX: begin
        hi_d    = mul_q ? prod_fix[63:32] : (rneg_q ? -r_q : r_q);
        lo_d    = mul_q ? prod_fix[31:0] : (neg_q ? -q_q : q_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      DZ: begin
        hi_d    = q_q;
        lo_d    = '1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      r_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      mul_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      r_q     <= r_d;
      q_q     <= q_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      mul_q   <= mul_d;
      done_q  <= done_d;
    end
  end

  assign busy    = state_q != IDLE;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign stall   = busy & start & (op >= OP_MULT) & (op <= OP_MFLO);
  assign rd_data = op == OP_MFHI ? hi_q : (op == OP_MFLO ? lo_q : '0);
endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// tb_mips_cpu_muldiv_seq: directed vector table plus hand sequences for stall, MT* and reset abort.
module tb_mips_cpu_muldiv_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, stall;
  logic [31:0] hi, lo, rd_data;
  int          n_vec = 0, n_err = 0;

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;
  vec_t vecs[13];

  mips_cpu_muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run(input vec_t v);
    int n;
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    chk({v.nm, " busy"}, busy, 1);
    wait_done(n);
    chk({v.nm, " latency"}, n, v.lat);
    chk({v.nm, " hi"}, hi, v.hi);
    chk({v.nm, " lo"}, lo, v.lo);
    tick();
    chk({v.nm, " done drop"}, done, 0);
  endtask

  initial begin
    int n, scnt;
    vecs[0]  = '{"multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[1]  = '{"mult_m3x7", 4'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
    vecs[2]  = '{"div_m7d2",  4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[3]  = '{"divu_100_7",4'd4, 32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[4]  = '{"div_ovf",   4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
    vecs[5]  = '{"div_dz",    4'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1};
    vecs[6]  = '{"divu_dz",   4'd4, 32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF, 1};
    vecs[7]  = '{"mult_minsq",4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         33};
    vecs[8]  = '{"mult_m1m1", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         33};
    vecs[9]  = '{"div_7dm2",  4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
    vecs[10] = '{"divu_max1", 4'd4, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 33};
    vecs[11] = '{"divu_3_10", 4'd4, 32'd3,         32'd10,        32'd3,         32'd0,         33};
    vecs[12] = '{"multu_sh",  4'd2, 32'h1234_5678, 32'h10,        32'd1,         32'h2345_6780, 33};

    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    chk("rst stall", stall, 0);
    chk("rst rd_data", rd_data, 0);
    #10 reset = 1'b1;
    tick();

    op = 4'd5; a = 32'hCAFE_0001; start = 1'b1;
    tick();
    chk("mthi hi", hi, 32'hCAFE_0001);
    chk("mthi busy", busy, 0);
    chk("mthi done", done, 0);
    start = 1'b0; op = 4'd7;
    #1 chk("mfhi rd_data", rd_data, 32'hCAFE_0001);
    op = 4'd8;
    #1 chk("mflo rd_data", rd_data, 0);
    op = 4'd0;

    for (int i = 0; i < 13; i++) run(vecs[i]);

    op = 4'd1; a = 32'd6; b = 32'hFFFF_FFF9; start = 1'b1;
    tick();
    op = 4'd8;
    scnt = 0; n = 0;
    while (!done && n < 40) begin
      if (stall) scnt++;
      tick();
      n++;
    end
    chk("mflo stall cycles", scnt, 33);
    chk("mflo done stall", stall, 0);
    chk("mflo done rd_data", rd_data, 32'hFFFF_FFD6);
    chk("mult6 hi", hi, 32'hFFFF_FFFF);

    op = 4'd2; a = 32'd3; b = 32'd5;
    tick();
    op = 4'd5; a = 32'h1234;
    repeat (5) tick();
    chk("mthi busy stall", stall, 1);
    chk("mthi held hi", hi, 32'hFFFF_FFFF);
    wait_done(n);
    chk("multu35 hi", hi, 0);
    chk("multu35 lo", lo, 32'd15);
    chk("mthi done stall", stall, 0);
    tick();
    start = 1'b0;
    chk("mthi landed", hi, 32'h1234);
    chk("mthi lo kept", lo, 32'd15);

    op = 4'd4; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort hi", hi, 0);
    chk("abort lo", lo, 0);
    chk("abort done", done, 0);
    #1 reset = 1'b1;
    op = 4'd6; a = 32'hA5A5_A5A5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mtlo lo", lo, 32'hA5A5_A5A5);
    chk("mtlo busy", busy, 0);
    tick();
    chk("mtlo no done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
